unit_jump_resolve: RTL and testbench

Registered branch/jump resolution unit, the parametrised successor of the combinational ID-stage jump unit. It accepts one control-transfer op per cycle from ID, evaluates condition and target, and compares the outcome against the fetch prediction. It emits a single-entry registered redirect to IF through a valid/ready handshake. An optional return-address stack (RAS) supplies call/return predictions to IF.

---
 rtl/unit_jump_resolve.sv | 165 ++++++++++++++++
 tb/tb_unit_jump_resolve.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unit_jump_resolve.sv
// Purpose : registered branch/jump resolution; checks the fetch prediction and raises a redirect to IF.
// Latency : 1 cycle from accept to redirValid_out / misalign_out; the RAS top updates on the same edge.
// Backpr. : single-entry redirect; ready_out drops while a redirect waits and redirReady_in is low.
//
// Ports:
//   clk_in, rstN_in             clock (rising edge), asynchronous active-low reset
//   flush_in                    kills the op being offered and any pending redirect
//   valid_in / ready_out        op handshake from ID
//   jumpOp_in                   one-hot {IJ, J, B}; 000 = not a transfer
//   brFunct3_in                 branch condition select
//   srcA_in, srcB_in, imm_in,   operands, immediate and op PC
//   pc_in
//   rdIdx_in, rs1Idx_in         register indices, used for call/return detection
//   predTaken_in, predAddr_in   prediction made by IF
//   redirValid_out / redirReady_in, redirAddr_out   redirect handshake to IF
//   misalign_out                one-cycle pulse on a misaligned taken target
//   rasValid_out, rasTop_out    return-address stack state
// Optional feature: RVX_JUMP_RAS_EN enables the return-address stack.
module unit_jump_resolve #(
  parameter int XLEN      = 32,
  parameter int IALIGN    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk_in,
  input  logic            rstN_in,
  input  logic            flush_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [2:0]      jumpOp_in,
  input  logic [2:0]      brFunct3_in,
  input  logic [XLEN-1:0] srcA_in,
  input  logic [XLEN-1:0] srcB_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [4:0]      rdIdx_in,
  input  logic [4:0]      rs1Idx_in,
  input  logic            predTaken_in,
  input  logic [XLEN-1:0] predAddr_in,
  output logic            redirValid_out,
  output logic [XLEN-1:0] redirAddr_out,
  input  logic            redirReady_in,
  output logic            misalign_out,
  output logic            rasValid_out,
  output logic [XLEN-1:0] rasTop_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0]      state;
  logic [XLEN-1:0] redir_addr_q;
  logic            misalign_q;

  logic            is_b, is_j, is_ij;
  logic            cond, taken, mispredict, misalign_hit, accept;
  logic [XLEN-1:0] sum_ij, target, fall_pc, next_pc;

  assign is_b  = jumpOp_in[0];
  assign is_j  = jumpOp_in[1];
  assign is_ij = jumpOp_in[2];

  always_comb begin
    cond = 1'b0;
    case (brFunct3_in)
      3'b000:  cond = (srcA_in == srcB_in);
      3'b001:  cond = (srcA_in != srcB_in);
      3'b100:  cond = ($signed(srcA_in) <  $signed(srcB_in));
      3'b101:  cond = ($signed(srcA_in) >= $signed(srcB_in));
      3'b110:  cond = (srcA_in <  srcB_in);
      3'b111:  cond = (srcA_in >= srcB_in);
      default: cond = 1'b0;
    endcase
  end

  assign sum_ij  = srcA_in + imm_in;
  assign target  = is_ij ? {sum_ij[XLEN-1:1], 1'b0} : (pc_in + imm_in);
  assign fall_pc = pc_in + XLEN'(4);
  assign taken   = is_j | is_ij | (is_b & cond);
  assign next_pc = taken ? target : fall_pc;

  assign mispredict = (taken != predTaken_in) | (taken & (target != predAddr_in));
  // With 16-bit alignment bit0 is already forced low, so nothing can be misaligned.
  assign misalign_hit = (IALIGN == 32) && taken && target[1];

  assign ready_out = (state == ST_IDLE) | redirReady_in;
  assign accept    = valid_in & ready_out & ~flush_in & (|jumpOp_in);

  // A new accept while pending is only possible with redirReady_in high,
  // so loading a fresh redirect replaces the one IF is taking this cycle.
  always_ff @(posedge clk_in or negedge rstN_in) begin
    if (!rstN_in) begin
      state        <= ST_IDLE;
      redir_addr_q <= '0;
      misalign_q   <= 1'b0;
    end else if (flush_in) begin
      state      <= ST_IDLE;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept & misalign_hit;
      if (accept & ~misalign_hit & mispredict) begin
        state        <= ST_PEND;
        redir_addr_q <= next_pc;
      end else if (redirReady_in) begin
        state <= ST_IDLE;
      end
    end
  end

  assign redirValid_out = (state == ST_PEND);
  assign redirAddr_out  = redir_addr_q;
  assign misalign_out   = misalign_q;

`ifdef RVX_JUMP_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;
  logic [CW-1:0]   ras_cnt;
  logic            ras_push, ras_pop, ras_replace, ras_do_push, ras_do_pop;

  function automatic logic is_link(input logic [4:0] idx);
    return (idx == 5'd1) || (idx == 5'd5);
  endfunction

  assign ras_push = accept & (is_j | is_ij) & is_link(rdIdx_in);
  assign ras_pop  = accept & is_ij & is_link(rs1Idx_in) & ~is_link(rdIdx_in);

  // Push+pop on a non-empty stack rewrites the top in place; on an empty
  // stack the pop is a no-op so it degenerates to a plain push.
  assign ras_replace = ras_push & ras_pop & (ras_cnt != '0);
  assign ras_do_push = ras_push & ~ras_replace;
  assign ras_do_pop  = ras_pop & ~ras_push & (ras_cnt != '0);

  // Circular pointer: pushing when full overwrites the oldest slot.
  always_ff @(posedge clk_in or negedge rstN_in) begin
    if (!rstN_in) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_do_push) begin
      ras_ptr <= ras_ptr + PW'(1);
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
    end else if (ras_do_pop) begin
      ras_ptr <= ras_ptr - PW'(1);
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (ras_replace)      ras_mem[ras_ptr]          <= fall_pc;
    else if (ras_do_push) ras_mem[ras_ptr + PW'(1)] <= fall_pc;
  end

  assign rasValid_out = (ras_cnt != '0);
  assign rasTop_out   = rasValid_out ? ras_mem[ras_ptr] : '0;
`else
  logic        unused_ras_idx;
  logic [31:0] unused_ras_depth;
  assign unused_ras_idx   = ^{rdIdx_in, rs1Idx_in};
  assign unused_ras_depth = RAS_DEPTH;
  assign rasValid_out     = 1'b0;
  assign rasTop_out       = '0;
`endif

endmodule

// File: tb/tb_unit_jump_resolve.sv
module tb_unit_jump_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, valid, valid16, rr;
  logic [2:0]  op, f3;
  logic [31:0] a, b, imm, pc, pa;
  logic [4:0]  rd, rs1;
  logic        pt;

  logic        rdy, rv, mis, rasv;
  logic [31:0] raddr, rtop;
  logic        rdy16, rv16, mis16, rasv16;
  logic [31:0] raddr16, rtop16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unit_jump_resolve #(.XLEN(32), .IALIGN(32), .RAS_DEPTH(4)) u_dut (
    .clk_in(clk), .rstN_in(rst_n), .flush_in(flush), .valid_in(valid), .ready_out(rdy),
    .jumpOp_in(op), .brFunct3_in(f3), .srcA_in(a), .srcB_in(b), .imm_in(imm), .pc_in(pc),
    .rdIdx_in(rd), .rs1Idx_in(rs1), .predTaken_in(pt), .predAddr_in(pa),
    .redirValid_out(rv), .redirAddr_out(raddr), .redirReady_in(rr),
    .misalign_out(mis), .rasValid_out(rasv), .rasTop_out(rtop));

  unit_jump_resolve #(.XLEN(32), .IALIGN(16), .RAS_DEPTH(4)) u_dut16 (
    .clk_in(clk), .rstN_in(rst_n), .flush_in(flush), .valid_in(valid16), .ready_out(rdy16),
    .jumpOp_in(op), .brFunct3_in(f3), .srcA_in(a), .srcB_in(b), .imm_in(imm), .pc_in(pc),
    .rdIdx_in(rd), .rs1Idx_in(rs1), .predTaken_in(pt), .predAddr_in(pa),
    .redirValid_out(rv16), .redirAddr_out(raddr16), .redirReady_in(rr),
    .misalign_out(mis16), .rasValid_out(rasv16), .rasTop_out(rtop16));

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, b, imm, pc;
    logic        pt;
    logic [31:0] pa;
    logic        e_redir;
    logic [31:0] e_addr;
    logic        e_mis;
  } vec_t;

  typedef struct packed {
    logic        redir;
    logic [31:0] addr;
    logic        mis;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];

  localparam logic [2:0] OP_B = 3'b001, OP_J = 3'b010, OP_IJ = 3'b100;

  function automatic vec_t mk(input logic [2:0] o, input logic [2:0] f, input logic [31:0] va,
                              input logic [31:0] vb, input logic [31:0] vi, input logic [31:0] vp,
                              input logic vpt, input logic [31:0] vpa, input logic er,
                              input logic [31:0] ea, input logic em);
    vec_t v;
    v.op = o; v.f3 = f; v.a = va; v.b = vb; v.imm = vi; v.pc = vp;
    v.pt = vpt; v.pa = vpa; v.e_redir = er; v.e_addr = ea; v.e_mis = em;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [2:0] f, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] vi, input logic [31:0] vp,
                       input logic vpt, input logic [31:0] vpa);
    op = o; f3 = f; a = va; b = vb; imm = vi; pc = vp; pt = vpt; pa = vpa;
  endtask

  // Wait for the active edge and step off it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; valid16 = 1'b0; rr = 1'b1;
    rd = 5'd0; rs1 = 5'd0;
    drive(3'b000, 3'b000, 0, 0, 0, 0, 1'b0, 0);

    vecs[0]  = mk(OP_B,  3'b000, 32'h5, 32'h5, 32'h20, 32'h100, 1'b0, 32'h0, 1'b1, 32'h120, 1'b0);
    vecs[1]  = mk(OP_B,  3'b100, 32'hFFFFFFFF, 32'h1, 32'h40, 32'h200, 1'b0, 32'h0, 1'b1, 32'h240, 1'b0);
    vecs[2]  = mk(OP_B,  3'b110, 32'hFFFFFFFF, 32'h1, 32'h40, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    vecs[3]  = mk(OP_IJ, 3'b000, 32'h203, 32'h0, 32'h0, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    vecs[4]  = mk(OP_J,  3'b000, 32'h0, 32'h0, 32'h10, 32'h1000, 1'b1, 32'h1010, 1'b0, 32'h0, 1'b0);
    vecs[5]  = mk(OP_J,  3'b000, 32'h0, 32'h0, 32'h10, 32'h1000, 1'b1, 32'h1014, 1'b1, 32'h1010, 1'b0);
    vecs[6]  = mk(OP_B,  3'b001, 32'h3, 32'h3, 32'h8, 32'h300, 1'b1, 32'h308, 1'b1, 32'h304, 1'b0);
    vecs[7]  = mk(OP_B,  3'b101, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'h400, 1'b1, 32'h3F0, 1'b0, 32'h0, 1'b0);
    vecs[8]  = mk(OP_B,  3'b111, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'h400, 1'b1, 32'h3F0, 1'b1, 32'h404, 1'b0);
    vecs[9]  = mk(OP_B,  3'b010, 32'h7, 32'h7, 32'h8, 32'h500, 1'b1, 32'h508, 1'b1, 32'h504, 1'b0);
    vecs[10] = mk(OP_IJ, 3'b000, 32'h1001, 32'h0, 32'h100, 32'h600, 1'b0, 32'h0, 1'b1, 32'h1100, 1'b0);
    vecs[11] = mk(3'b000, 3'b000, 32'h0, 32'h0, 32'h40, 32'h700, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    vecs[12] = mk(OP_J,  3'b000, 32'h0, 32'h0, 32'h2, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    vecs[13] = mk(OP_J,  3'b000, 32'h0, 32'h0, 32'h20, 32'hFFFFFFF0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
    vecs[14] = mk(OP_B,  3'b000, 32'h1, 32'h2, 32'h40, 32'hFFFFFFFC, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0);

    // Reset values
    #12;
    chk("rst redirValid", 32'(rv), 0);
    chk("rst redirAddr", raddr, 0);
    chk("rst misalign", 32'(mis), 0);
    chk("rst rasValid", 32'(rasv), 0);
    chk("rst rasTop", rtop, 0);
    chk("rst ready", 32'(rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-op checks, redirReady held high
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc, vecs[i].pt, vecs[i].pa);
      valid = 1'b1;
      sb.push_back('{redir: vecs[i].e_redir, addr: vecs[i].e_addr, mis: vecs[i].e_mis});
      tick();
      valid = 1'b0;
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL v%0d scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d redirValid", i), 32'(rv), 32'(e.redir));
        if (e.redir) chk($sformatf("v%0d redirAddr", i), raddr, e.addr);
        chk($sformatf("v%0d misalign", i), 32'(mis), 32'(e.mis));
      end
    end
    @(negedge clk);
    tick();
    chk("drain redirValid", 32'(rv), 0);

    // IALIGN=16 instance: bit0 cleared, never misaligned
    @(negedge clk);
    drive(OP_IJ, 3'b000, 32'h203, 0, 0, 32'h80, 1'b1, 32'h202);
    valid16 = 1'b1;
    tick();
    chk("ia16 misalign", 32'(mis16), 0);
    chk("ia16 redirValid", 32'(rv16), 0);
    @(negedge clk);
    pa = 32'h200;
    tick();
    chk("ia16 mp redirValid", 32'(rv16), 1);
    chk("ia16 mp redirAddr", raddr16, 32'h202);
    chk("ia16 mp misalign", 32'(mis16), 0);
    valid16 = 1'b0;

    // Backpressure: redirect held, ready low, address stable
    @(negedge clk);
    rr = 1'b0;
    drive(OP_B, 3'b000, 32'h5, 32'h5, 32'h20, 32'h100, 1'b0, 32'h0);
    valid = 1'b1;
    tick();
    chk("bp redirValid", 32'(rv), 1);
    chk("bp redirAddr", raddr, 32'h120);
    @(negedge clk);
    drive(OP_B, 3'b000, 32'h5, 32'h5, 32'h20, 32'h500, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp%0d ready", k), 32'(rdy), 0);
      chk($sformatf("bp%0d redirValid", k), 32'(rv), 1);
      chk($sformatf("bp%0d redirAddr", k), raddr, 32'h120);
    end
    @(negedge clk);
    flush = 1'b1;
    tick();
    chk("flush redirValid", 32'(rv), 0);
    // Flush beats a simultaneous accept, including a misaligned one
    @(negedge clk);
    rr = 1'b1;
    tick();
    chk("flush+acc redirValid", 32'(rv), 0);
    @(negedge clk);
    drive(OP_IJ, 3'b000, 32'h203, 0, 0, 32'h80, 1'b1, 32'h200);
    tick();
    chk("flush+acc misalign", 32'(mis), 0);
    @(negedge clk);
    flush = 1'b0;
    valid = 1'b0;

`ifdef RVX_JUMP_RAS_EN
    // RAS: five calls overflow a 4-deep stack, then unwind
    rd = 5'd1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive(OP_J, 3'b000, 0, 0, 32'h100, 32'(k * 16), 1'b1, 32'(k * 16 + 32'h100));
      valid = 1'b1;
      tick();
      chk($sformatf("call%0d rasValid", k), 32'(rasv), 1);
      chk($sformatf("call%0d rasTop", k), rtop, 32'(k * 16 + 4));
    end
    rd = 5'd0; rs1 = 5'd1;
    for (int k = 0; k < 5; k++) begin
      logic [31:0] ret_a, exp_top;
      ret_a   = (k < 4) ? 32'(32'h54 - k * 16) : 32'h0;
      exp_top = (k < 3) ? 32'(32'h44 - k * 16) : 32'h0;
      @(negedge clk);
      drive(OP_IJ, 3'b000, ret_a, 0, 0, 32'h900, 1'b1, ret_a);
      valid = 1'b1;
      tick();
      chk($sformatf("ret%0d rasTop", k), rtop, exp_top);
      chk($sformatf("ret%0d rasValid", k), 32'(rasv), (k < 3) ? 1 : 0);
      chk($sformatf("ret%0d redirValid", k), 32'(rv), 0);
    end
    rs1 = 5'd0;
`else
    @(negedge clk);
    rd = 5'd1;
    drive(OP_J, 3'b000, 0, 0, 32'h100, 32'h10, 1'b1, 32'h110);
    valid = 1'b1;
    tick();
    chk("noras rasValid", 32'(rasv), 0);
    chk("noras rasTop", rtop, 0);
`endif

    // Async reset in the middle of a pending redirect
    @(negedge clk);
    rr = 1'b0;
    rd = 5'd1;
    drive(OP_J, 3'b000, 0, 0, 32'h100, 32'h10, 1'b0, 32'h0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("pre-rst redirValid", 32'(rv), 1);
`ifdef RVX_JUMP_RAS_EN
    chk("pre-rst rasValid", 32'(rasv), 1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst redirValid", 32'(rv), 0);
    chk("async rst rasValid", 32'(rasv), 0);
    chk("async rst redirAddr", raddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rr = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
